cpu_trace_buffer: RTL and testbench
===================================

// Module: cpu_trace_buffer
// PURPOSE
//  Parametrised on-chip trace capture for the single-cycle CPU datapath. Replaces clock-only free-running
//  benches: records {pc, inst, alu} per committed cycle in a circular buffer, triggers on a PC match or a
//  force strobe, captures POST_TRIG further samples, then freezes for readout. Sits beside Datapath.
// PARAMETERS
//  DATA_W     32        width of pc, inst, alu
//  DEPTH      64        entries; power of two, >= 4
//  POST_TRIG  32        samples kept after the trigger sample; 0 .. DEPTH-1
//  ADDR_W     $clog2(DEPTH)  derived; do not override
// PORTS
//  clk        in   1          single clock, rising edge
//  clr        in   1          synchronous, active-high reset
//  smp_valid  in   1          sample strobe; one committed instruction per cycle
//  smp_pc     in   DATA_W     pc of the committed instruction
//  smp_inst   in   DATA_W     instruction word
//  smp_alu    in   DATA_W     alu result
//  arm        in   1          start capture (honoured in IDLE or DONE only)
//  trig_pc_en in   1          enable PC-match trigger
//  trig_pc    in   DATA_W     PC match value
//  trig_force in   1          immediate trigger on the current sample
//  rd_en      in   1          readout request
//  rd_addr    in   ADDR_W     index from oldest sample (0 = oldest)
//  rd_valid   out  1          readout data valid, 1 cycle after rd_en
//  rd_pc      out  DATA_W     readout fields
//  rd_inst    out  DATA_W
//  rd_alu     out  DATA_W
//  state      out  2          IDLE=0 ARMED=1 POST=2 DONE=3
//  count      out  ADDR_W+1   valid entries, saturates at DEPTH
//  trig_idx   out  ADDR_W     trigger sample index from oldest (valid in DONE)
// BEHAVIOUR
//  Reset (clr=1 at edge): state=IDLE, wr_ptr=0, count=0, trig_idx=0, post_cnt=0, rd_valid=0,
//   rd_* = 0. RAM contents not cleared. clr has priority over every other input, mid-capture included.
//  Trigger hit = smp_valid & (trig_force | (trig_pc_en & smp_pc==trig_pc)); only evaluated in ARMED.
//  IDLE : arm -> ARMED with wr_ptr=0, count=0. Samples ignored.
//  ARMED: each smp_valid writes RAM[wr_ptr], wr_ptr++ (mod DEPTH), count++ (saturate DEPTH).
//   On hit: sample written, trigger position latched, post_cnt=POST_TRIG;
//   POST_TRIG==0 -> DONE directly, else -> POST.
//  POST : each smp_valid writes, post_cnt--; the write taking post_cnt 1->0 moves to DONE.
//   Further trigger hits ignored.
//  DONE : no writes. arm -> ARMED with wr_ptr=0, count=0 (same cycle as arm; sample that cycle not stored).
//  arm in ARMED/POST ignored. arm and trig in same cycle from IDLE: arm only (trigger not evaluated).
//  Oldest entry: count<DEPTH -> RAM[0]; count==DEPTH -> RAM[wr_ptr]. Physical addr = oldest+rd_addr mod DEPTH.
//  trig_idx = (trigger physical addr - oldest physical addr) mod DEPTH, computed on entry to DONE.
//  Readout: rd_en accepted only in DONE; rd_valid=1 and data the next cycle (1-cycle sync read).
//   rd_addr >= count -> rd_valid=1, rd_* = 0. rd_en outside DONE -> rd_valid=0, rd_* hold last value.
//  Pre-trigger history kept = min(samples before trigger, DEPTH-1-POST_TRIG) once full; overwrite is
//   silent wrap.
// STRUCTURE
//  Shared package cpu_trace_pkg: state encoding (TR_IDLE..TR_DONE), sample record width 3*DATA_W.
//  One sub-module: trace_ram -- simple dual-port, DEPTH x 3*DATA_W, sync write, 1-cycle registered read.
//  Control FSM, pointers, and address translation stay in cpu_trace_buffer.
// TESTING
//  1 Reset mid-POST: clr pulse -> state=0, count=0, rd_valid=0 next cycle; re-arm captures from entry 0.
//  2 DEPTH=8, POST_TRIG=3, arm, pc=0,4,8..; trig_pc=0x14 -> DONE after pc=0x20; count=9? no: count=8,
//    rd 0..7 = pc 0x04..0x20, trig_idx=4.
//  3 trig_force on 3rd sample, POST_TRIG=0 -> DONE same edge; count=3, trig_idx=2,
//    rd_addr=2 returns that sample.
//  4 smp_valid gaps (1-of-3 cycles) in POST -> only strobed samples written/counted; DONE after exactly
//    POST_TRIG strobes.
//  5 Readout: rd_addr=5 with count=3 -> rd_valid=1, zeros; rd_en in ARMED -> rd_valid=0.
//  6 arm in DONE with trig_force same cycle -> ARMED, count=0, no trigger; next force triggers normally.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace buffer: capture state encoding and
// sample record sizing ({pc, inst, alu} packed into one RAM word).
package cpu_trace_pkg;

    typedef enum logic [1:0] {
        TR_IDLE  = 2'd0,
        TR_ARMED = 2'd1,
        TR_POST  = 2'd2,
        TR_DONE  = 2'd3
    } trace_state_e;

    localparam int FIELDS_PER_SAMPLE = 3;

    function automatic int rec_width(input int data_w);
        return FIELDS_PER_SAMPLE * data_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port sample store: synchronous write, registered read with a
// read enable so the output word holds between accepted reads.
module trace_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int REC_W  = 96
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [REC_W-1:0]  i_wr_data,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [REC_W-1:0]  o_rd_data
);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [REC_W-1:0] r_rd_data;

    // NOTE: the array has no reset on purpose; clearing it would force a
    // flop-based implementation instead of a RAM macro.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_re) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of committed {pc, inst, alu} samples with PC-match or
// forced trigger, POST_TRIG post-trigger samples, then freeze for readout.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              smp_valid,
    input  logic [DATA_W-1:0] smp_pc,
    input  logic [DATA_W-1:0] smp_inst,
    input  logic [DATA_W-1:0] smp_alu,
    input  logic              arm,
    input  logic              trig_pc_en,
    input  logic [DATA_W-1:0] trig_pc,
    input  logic              trig_force,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_pc,
    output logic [DATA_W-1:0] rd_inst,
    output logic [DATA_W-1:0] rd_alu,
    output logic [1:0]        state,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] trig_idx
);

    localparam int            REC_W     = rec_width(DATA_W);
    localparam logic [ADDR_W:0]   FULL  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] POST_N = ADDR_W'(POST_TRIG);

    trace_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_W:0]   r_count, w_count_nxt;
    logic [ADDR_W-1:0] r_post_cnt, w_post_cnt_nxt;
    logic [ADDR_W-1:0] r_trig_addr, w_trig_addr_nxt;
    logic [ADDR_W-1:0] r_trig_idx;
    logic              r_rd_valid;
    logic              r_rd_zero;

    logic              w_hit;
    logic              w_we;
    logic              w_done_entry;
    logic [ADDR_W-1:0] w_oldest_nxt;
    logic [ADDR_W-1:0] w_oldest;
    logic [ADDR_W-1:0] w_rd_phys;
    logic              w_rd_accept;
    logic              w_rd_oob;
    logic [REC_W-1:0]  w_ram_q;

    assign w_hit = smp_valid & (trig_force | (trig_pc_en & (smp_pc == trig_pc)));

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_count_nxt     = r_count;
        w_post_cnt_nxt  = r_post_cnt;
        w_trig_addr_nxt = r_trig_addr;
        w_we            = 1'b0;
        w_done_entry    = 1'b0;

        case (r_state)
            TR_IDLE, TR_DONE: begin
                if (arm) begin
                    w_state_nxt  = TR_ARMED;
                    w_wr_ptr_nxt = '0;
                    w_count_nxt  = '0;
                end
            end
            TR_ARMED, TR_POST: begin
                if (smp_valid) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    w_count_nxt  = (r_count == FULL) ? r_count : r_count + 1'b1;
                    if (r_state == TR_ARMED) begin
                        if (w_hit) begin
                            w_trig_addr_nxt = r_wr_ptr;
                            w_post_cnt_nxt  = POST_N;
                            if (POST_TRIG == 0) begin
                                w_state_nxt  = TR_DONE;
                                w_done_entry = 1'b1;
                            end else begin
                                w_state_nxt = TR_POST;
                            end
                        end
                    end else begin
                        w_post_cnt_nxt = r_post_cnt - 1'b1;
                        if (r_post_cnt == ADDR_W'(1)) begin
                            w_state_nxt  = TR_DONE;
                            w_done_entry = 1'b1;
                        end
                    end
                end
            end
            default: w_state_nxt = TR_IDLE;
        endcase
    end

    // Trigger index is relative to the oldest entry as it will be after this write.
    assign w_oldest_nxt = (w_count_nxt == FULL) ? w_wr_ptr_nxt : '0;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= TR_IDLE;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_trig_addr <= '0;
            r_trig_idx  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_count     <= w_count_nxt;
            r_post_cnt  <= w_post_cnt_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            if (w_done_entry) begin
                r_trig_idx <= w_trig_addr_nxt - w_oldest_nxt;
            end
        end
    end

    assign w_oldest    = (r_count == FULL) ? r_wr_ptr : '0;
    assign w_rd_phys   = w_oldest + rd_addr;
    assign w_rd_accept = rd_en & (r_state == TR_DONE);
    assign w_rd_oob    = ({1'b0, rd_addr} >= r_count);

    // r_rd_zero starts set so rd_* read as zero after reset without touching the RAM.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_rd_valid <= 1'b0;
            r_rd_zero  <= 1'b1;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_zero <= w_rd_oob;
            end
        end
    end

    trace_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .REC_W  (REC_W)
    ) u_ram (
        .clk       (clk),
        .i_we      (w_we),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data ({smp_pc, smp_inst, smp_alu}),
        .i_re      (w_rd_accept),
        .i_rd_addr (w_rd_phys),
        .o_rd_data (w_ram_q)
    );

    assign {rd_pc, rd_inst, rd_alu} = r_rd_zero ? '0 : w_ram_q;
    assign rd_valid = r_rd_valid;
    assign state    = r_state;
    assign count    = r_count;
    assign trig_idx = r_trig_idx;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench: two trace buffers (POST_TRIG=3 and POST_TRIG=0, DEPTH=8)
// share one stimulus stream; each step checks the instance it targets.
module tb_cpu_trace_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              clr;
    logic              smp_valid;
    logic [DATA_W-1:0] smp_pc, smp_inst, smp_alu;
    logic              arm;
    logic              trig_pc_en;
    logic [DATA_W-1:0] trig_pc;
    logic              trig_force;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    logic              a_rd_valid, b_rd_valid;
    logic [DATA_W-1:0] a_rd_pc, a_rd_inst, a_rd_alu;
    logic [DATA_W-1:0] b_rd_pc, b_rd_inst, b_rd_alu;
    logic [1:0]        a_state, b_state;
    logic [ADDR_W:0]   a_count, b_count;
    logic [ADDR_W-1:0] a_trig_idx, b_trig_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(3)) dut_a (
        .clk(clk), .clr(clr), .smp_valid(smp_valid), .smp_pc(smp_pc),
        .smp_inst(smp_inst), .smp_alu(smp_alu), .arm(arm),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_force(trig_force),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(a_rd_valid),
        .rd_pc(a_rd_pc), .rd_inst(a_rd_inst), .rd_alu(a_rd_alu),
        .state(a_state), .count(a_count), .trig_idx(a_trig_idx)
    );

    cpu_trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .POST_TRIG(0)) dut_b (
        .clk(clk), .clr(clr), .smp_valid(smp_valid), .smp_pc(smp_pc),
        .smp_inst(smp_inst), .smp_alu(smp_alu), .arm(arm),
        .trig_pc_en(trig_pc_en), .trig_pc(trig_pc), .trig_force(trig_force),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(b_rd_valid),
        .rd_pc(b_rd_pc), .rd_inst(b_rd_inst), .rd_alu(b_rd_alu),
        .state(b_state), .count(b_count), .trig_idx(b_trig_idx)
    );

    function automatic logic [DATA_W-1:0] inst_of(input logic [DATA_W-1:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic logic [DATA_W-1:0] alu_of(input logic [DATA_W-1:0] pc);
        return pc + 32'h0000_1000;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sample(input logic v, input logic [DATA_W-1:0] pc, input logic frc);
        smp_valid  = v;
        smp_pc     = pc;
        smp_inst   = inst_of(pc);
        smp_alu    = alu_of(pc);
        trig_force = frc;
        step();
        smp_valid  = 1'b0;
        trig_force = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a);
        rd_en   = 1'b1;
        rd_addr = a;
        step();
        rd_en   = 1'b0;
    endtask

    initial begin
        clr = 1'b1; smp_valid = 1'b0; smp_pc = '0; smp_inst = '0; smp_alu = '0;
        arm = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; trig_force = 1'b0;
        rd_en = 1'b0; rd_addr = '0;
        step();
        step();
        clr = 1'b0;

        check("rst_state", 64'(a_state), 64'd0);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_rd_valid", 64'(a_rd_valid), 64'd0);
        check("rst_rd_pc", 64'(a_rd_pc), 64'd0);

        // Forced trigger on the third sample, POST_TRIG=0 instance.
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("b_armed", 64'(b_state), 64'd1);
        drive_sample(1'b1, 32'h200, 1'b0);
        drive_sample(1'b1, 32'h204, 1'b0);
        check("b_count2", 64'(b_count), 64'd2);
        drive_sample(1'b1, 32'h208, 1'b1);
        check("b_done_same_edge", 64'(b_state), 64'd3);
        check("b_count3", 64'(b_count), 64'd3);
        check("b_trig_idx2", 64'(b_trig_idx), 64'd2);
        check("a_post_after_force", 64'(a_state), 64'd2);
        do_read(3'd2);
        check("b_rd2_valid", 64'(b_rd_valid), 64'd1);
        check("b_rd2_pc", 64'(b_rd_pc), 64'h208);
        check("b_rd2_inst", 64'(b_rd_inst), 64'(inst_of(32'h208)));
        check("b_rd2_alu", 64'(b_rd_alu), 64'(alu_of(32'h208)));

        // Out-of-range read, and read while not in DONE.
        do_read(3'd5);
        check("b_oob_valid", 64'(b_rd_valid), 64'd1);
        check("b_oob_pc", 64'(b_rd_pc), 64'd0);
        check("b_oob_alu", 64'(b_rd_alu), 64'd0);
        check("a_rd_in_post", 64'(a_rd_valid), 64'd0);
        do_read(3'd2);
        check("b_reread_pc", 64'(b_rd_pc), 64'h208);

        // arm in DONE together with a forced trigger: arm only.
        arm = 1'b1;
        drive_sample(1'b1, 32'h300, 1'b1);
        arm = 1'b0;
        check("b_rearm_state", 64'(b_state), 64'd1);
        check("b_rearm_count", 64'(b_count), 64'd0);
        do_read(3'd0);
        check("b_rd_armed_valid", 64'(b_rd_valid), 64'd0);
        check("b_rd_armed_hold", 64'(b_rd_pc), 64'h208);
        drive_sample(1'b1, 32'h304, 1'b1);
        check("b_force2_state", 64'(b_state), 64'd3);
        check("b_force2_count", 64'(b_count), 64'd1);
        check("b_force2_idx", 64'(b_trig_idx), 64'd0);
        do_read(3'd0);
        check("b_force2_rd_pc", 64'(b_rd_pc), 64'h304);

        // Reset in the middle of POST.
        check("a_still_post", 64'(a_state), 64'd2);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("a_clr_state", 64'(a_state), 64'd0);
        check("a_clr_count", 64'(a_count), 64'd0);
        check("a_clr_rd_valid", 64'(a_rd_valid), 64'd0);
        check("b_clr_rd_valid", 64'(b_rd_valid), 64'd0);

        // PC-match trigger at 0x14 with wrap: pc 0x00..0x20 captured.
        trig_pc_en = 1'b1;
        trig_pc    = 32'h14;
        arm = 1'b1;
        step();
        arm = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_sample(1'b1, 32'(4 * i), 1'b0);
            if (i == 5) begin
                check("a_post_on_match", 64'(a_state), 64'd2);
            end
        end
        trig_pc_en = 1'b0;
        check("a_wrap_state", 64'(a_state), 64'd3);
        check("a_wrap_count", 64'(a_count), 64'd8);
        check("a_wrap_trig_idx", 64'(a_trig_idx), 64'd4);
        check("b_match_count", 64'(b_count), 64'd6);
        check("b_match_trig_idx", 64'(b_trig_idx), 64'd5);
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            check($sformatf("a_wrap_rd%0d_pc", i), 64'(a_rd_pc), 64'(4 * (i + 1)));
            if (i == 0) begin
                check("a_wrap_rd0_inst", 64'(a_rd_inst), 64'(inst_of(32'h4)));
                check("a_wrap_rd0_alu", 64'(a_rd_alu), 64'(alu_of(32'h4)));
            end
        end

        // Sparse strobes in POST: only strobed cycles count toward POST_TRIG.
        arm = 1'b1;
        step();
        arm = 1'b0;
        drive_sample(1'b1, 32'h100, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive_sample(1'b0, 32'h0, 1'b0);
            drive_sample(1'b0, 32'h0, 1'b0);
            check($sformatf("a_gap_post%0d", k), 64'(a_state), 64'd2);
            drive_sample(1'b1, 32'(32'h104 + 4 * k), 1'b0);
        end
        check("a_gap_done", 64'(a_state), 64'd3);
        check("a_gap_count", 64'(a_count), 64'd4);
        check("a_gap_trig_idx", 64'(a_trig_idx), 64'd0);
        do_read(3'd3);
        check("a_gap_rd3_pc", 64'(a_rd_pc), 64'h10c);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
